// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide responder for the E stage of the pipelined MIPS core.
// Accepts mult/multu/div/divu, owns HI/LO, serves mthi/mtlo writes and the
// combinational mfhi/mflo read, and raises busy while an operation is in flight.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        read_hi,
  output logic        busy,
  output logic [31:0] read_data,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MFX   = 3'd7
  } op_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  op_e         op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  logic [63:0] ext_a, ext_b, product;
  logic        neg_a, neg_b;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] quot, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_write;

  // Result of the latched operation, consumed only at the completion edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    res_hi    = hi_q;
    res_lo    = lo_q;
    res_write = 1'b0;

    // Sign-extension makes the low 64 bits of a plain 64x64 product equal the
    // signed 32x32 product, so one multiplier serves both mult and multu.
    ext_a   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    ext_b   = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    product = ext_a * ext_b;

    // Signed divide runs on magnitudes; 0x80000000 stays 0x80000000 as an
    // unsigned magnitude, so the -2^31 / -1 case wraps to 0x80000000 naturally.
    neg_a = (op_q == OP_DIV) && a_q[31];
    neg_b = (op_q == OP_DIV) && b_q[31];
    a_mag = neg_a ? -a_q : a_q;
    b_mag = neg_b ? -b_q : b_q;
    q_mag = (b_q == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag = (b_q == 32'd0) ? 32'd0 : a_mag % b_mag;
    quot  = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem   = neg_a ? -r_mag : r_mag;

    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_write = 1'b1;
        res_hi    = product[63:32];
        res_lo    = product[31:0];
      end
      OP_DIV, OP_DIVU: begin
        // Divide by zero leaves HI/LO untouched.
        res_write = (b_q != 32'd0);
        res_hi    = rem;
        res_lo    = quot;
      end
      default: ;
    endcase
  end

  // Request acceptance, cycle countdown and HI/LO updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: operand/op registers are reset too so an aborted operation can never complete.
      cnt  <= 4'd0;
      op_q <= OP_NONE;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (cnt == 4'd0) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (start) begin
        case (op_e'(op))
          OP_MULT, OP_MULTU: begin
            op_q <= op_e'(op);
            a_q  <= operand1;
            b_q  <= operand2;
            cnt  <= MULT_LOAD;
          end
          OP_DIV, OP_DIVU: begin
            op_q <= op_e'(op);
            a_q  <= operand1;
            b_q  <= operand2;
            cnt  <= DIV_LOAD;
          end
          OP_MTHI: hi_q <= operand1;
          OP_MTLO: lo_q <= operand1;
          default: ;
        endcase
      end
    end else if (cnt == 4'd1) begin
      cnt <= 4'd0;
      if (res_write) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

  assign busy      = (cnt != 4'd0);
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign read_data = read_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand1, operand2;
  logic        read_hi;
  logic        busy;
  logic [31:0] read_data, HI, LO;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operand1 (operand1),
    .operand2 (operand2),
    .read_hi  (read_hi),
    .busy     (busy),
    .read_data(read_data),
    .HI       (HI),
    .LO       (LO)
  );

  // One comparison: count it, report a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted request on {HI, LO}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint la, lb, q, r;
    logic [63:0] p;
    case (o)
      3'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      3'd2: begin
        p = {32'b0, a} * {32'b0, b};
        return p;
      end
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q  = la / lb;
        r  = la % lb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      3'd5:    return {a, lo};
      3'd6:    return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  // Compare HI, LO and both read_data selections with the model.
  task automatic check_regs(input string tag);
    check({tag, "_hi"}, HI, m_hi);
    check({tag, "_lo"}, LO, m_lo);
    read_hi = 1'b1;
    #1 check({tag, "_rd_hi"}, read_data, m_hi);
    read_hi = 1'b0;
    #1 check({tag, "_rd_lo"}, read_data, m_lo);
  endtask

  // Issue one request, measure busy length, then check results. With
  // interfere set, MTLO and DIV requests are thrown at busy cycles 2 and 3.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit interfere);
    logic [63:0] r;
    int n, exp_n;
    @(negedge clk);
    start = 1'b1; op = o; operand1 = a; operand2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
    r = model(o, a, b, m_hi, m_lo);
    m_hi = r[63:32];
    m_lo = r[31:0];
    exp_n = (o == 3'd1 || o == 3'd2) ? MULT_N : (o == 3'd3 || o == 3'd4) ? DIV_N : 0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (interfere && n == 2) begin
        start = 1'b1; op = 3'd6; operand1 = 32'h0000ABCD;
      end else if (interfere && n == 3) begin
        start = 1'b1; op = 3'd3; operand1 = 32'd9; operand2 = 32'd3;
      end else begin
        start = 1'b0; operand1 = $urandom; operand2 = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
    check_regs(tag);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;

    reset = 1'b1; start = 1'b0; op = 3'd0;
    operand1 = 32'd0; operand2 = 32'd0; read_hi = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check_regs("reset");

    run_op("mult_neg", 3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    check("mult_neg_hi_const", HI, 32'hFFFFFFFF);
    check("mult_neg_lo_const", LO, 32'hFFFFFFFE);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    run_op("divu_7_2", 3'd4, 32'd7, 32'd2, 1'b0);
    run_op("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lo_const", LO, 32'h80000000);
    run_op("mthi", 3'd5, 32'h00000011, 32'd0, 1'b0);
    run_op("mtlo", 3'd6, 32'h00000022, 32'd0, 1'b0);
    run_op("div_by0", 3'd3, 32'd5, 32'd0, 1'b0);
    run_op("nop0", 3'd0, 32'h12345678, 32'h1, 1'b0);
    run_op("nop7", 3'd7, 32'h12345678, 32'h1, 1'b0);
    run_op("mult_busy_ign", 3'd1, 32'd3, 32'd4, 1'b1);

    // Randomized traffic with occasional zero divisors and the overflow pair.
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, 1'b0);
    end

    // Asynchronous reset in the middle of a divide.
    run_op("pre_rst", 3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd3; operand1 = 32'd100; operand2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_hi", HI, 32'd0);
    check("async_rst_lo", LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check_regs("post_rst");
    run_op("mult_2_3", 3'd1, 32'd2, 32'd3, 1'b0);
    check("mult_2_3_lo_const", LO, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Responder side of the HI/LO request interface issued from the E stage of the pipelined MIPS core.
- Accepts mult/multu/div/divu start requests and owns the HI and LO registers.
- Serves mthi/mtlo writes and the combinational mfhi/mflo read.
- Reports `busy` so the hazard control can stall HI/LO-dependent instructions in D.

Parameters:
- MULT_CYCLES, 5, number of cycles `busy` stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of cycles `busy` stays high for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request valid from E stage; qualifies op.
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI/MFLO-select (see read_data).
- operand1  input  32  rs value (already forwarded).
- operand2  input  32  rt value (already forwarded).
- read_hi  input  1  1 selects HI onto read_data, 0 selects LO.
- busy  output  1  high while a multiply/divide is in flight.
- read_data  output  32  combinational, equals read_hi ? HI : LO.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - HI=0, LO=0, busy=0, cycle counter=0.
  - Captured operands and the pending op are discarded; no later HI/LO write occurs.
- Internal state: 4-bit counter `cnt`, latched op, latched operands. busy = (cnt != 0); there is no other state.
- Accept rule: at a clock edge with start=1, busy=0 and op in {1..4}:
  - operand1, operand2 and op are latched.
  - cnt loads MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
  - busy rises in the following cycle.
- Count: each edge with cnt>1 decrements cnt.
- Completion: at the edge where cnt==1:
  - cnt becomes 0 and HI/LO are written in the same edge.
  - New HI/LO values and busy=0 are visible together in the cycle after that edge.
  - busy is therefore high for exactly N cycles; results appear N+1 cycles after the accept cycle.
- start=1 while busy=1 is ignored for all ops, including MTHI/MTLO. The core must stall, and the hazard unit uses (busy | start&&op in 1..4) as its stall term.
- MTHI/MTLO: at an edge with start=1, busy=0, op=5/6, HI/LO is written with operand1. Takes effect in the next cycle; busy stays 0.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI=product[63:32], LO=product[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Division by zero: busy still runs DIV_CYCLES; HI and LO are left unchanged at completion.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- Results are computed from the latched operands only. Operand changes after acceptance have no effect.
- op=0 or op=7 with start=1: no state change.
- read_data is purely combinational from HI/LO and does not reflect an in-flight result until completion.

Test Plan:
- Reset check: after reset, HI=0, LO=0, busy=0. Then MULT 0xFFFFFFFF x 0x00000002 → busy high for exactly 5 cycles; next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU 0xFFFFFFFF x 0x00000002 → HI=0x00000001, LO=0xFFFFFFFE. Then DIVU 7/2 → busy 10 cycles, LO=3, HI=1.
- DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV 5/0 → busy 10 cycles; HI=0x11, LO=0x22 afterwards. read_hi toggles read_data between 0x11 and 0x22.
- Ignored requests during MULT 3x4 in flight:
  - MTLO 0xABCD at cycle 2 of busy → ignored.
  - DIV 9/3 at cycle 3 of busy → ignored.
  - Final HI=0, LO=0xC; busy duration unchanged.
  - Operands changed after acceptance do not alter the result.
- Assert reset asynchronously (between edges) during cycle 3 of a DIV → busy, HI and LO drop to 0 immediately. After release, no result write occurs; a new MULT 2x3 gives LO=6.
